wb_stage_pipe: RTL and testbench
================================

# wb_stage_pipe

Parametrised, registered write-back stage for the multicycle R/I/J CPU. It decodes IR, selects the write-back source (ALUo, LMD with sub-word extraction, or NPC for link) and drives the register-file write port one cycle after an instruction is accepted. It also flags misaligned loads and counts retired instructions. It sits between the MEM stage latches (LMD, ALUo, IR, NPC) and the register file.

## Interface
- DATA_W, 32: datapath width; must be ≥ 32.
- LINK_REG, 31: destination register for jal.
- CNT_W, 32: width of the retire counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  LMD/ALUo/IR/NPC hold an instruction to retire.
- hold  in  1  freeze; blocks acceptance.
- in_ready  out  1  combinational, equal to !hold.
- LMD  in  DATA_W  loaded memory word.
- ALUo  in  DATA_W  ALU result; also the effective address for loads.
- IR  in  32  instruction word.
- NPC  in  DATA_W  PC+4, used as the link value.
- WB_Write  out  1  register-file write enable.
- WB_Addr  out  5  destination register.
- WB_Data  out  DATA_W  write data.
- WB_Err  out  1  one-cycle pulse on a misaligned load.
- Err_IR  out  32  IR of the last misaligned load.
- Retired  out  CNT_W  count of accepted instructions.

## Operation
- Accept = in_valid && !hold && !rst.
- Decode of a writing instruction:
  - R-type: opcode 000000. Funct is one of add/addu/sub/subu/and/or/xor/nor/slt/sltu (100000–100111, 101010, 101011) or sll/srl/sra (000000, 000010, 000011). Destination is rd = IR[15:11]; data is ALUo.
  - I-type ALU: opcode 001000/001001/001010/001011/001100/001101/001110/001111. Destination is rt = IR[20:16]; data is ALUo.
  - lw: opcode 100011. Destination is rt; data is LMD.
  - lb (100000) and lbu (100100): big-endian byte select. ALUo[1:0] = k selects LMD[31-8k -: 8]. lb sign-extends to DATA_W; lbu zero-extends.
  - lh (100001) and lhu (100101): ALUo[1] = 0 selects LMD[31:16]; ALUo[1] = 1 selects LMD[15:0]. lh sign-extends; lhu zero-extends.
  - jal: opcode 000011. Destination is LINK_REG; data is NPC.
- Every other encoding does not write. This includes jr (R-type, funct 001000), any other R-type funct, sw, beq, bne, j and undefined opcodes.
- A write to register 0 is suppressed: WB_Write = 0 and the instruction still retires. IR = 0 (sll $0,$0,0) is therefore a retiring no-op.
- Misaligned load: lw with ALUo[1:0] ≠ 0, or lh/lhu with ALUo[0] = 1.
  - No write occurs.
  - WB_Err pulses for one cycle.
  - Err_IR captures IR.
  - The instruction still retires.
- Retired increments by 1 on every accept, including non-writing instructions. It wraps modulo 2^CNT_W.

## Timing
- Reset values, one cycle after rst is high at an edge: WB_Write = 0, WB_Addr = 0, WB_Data = 0, WB_Err = 0, Err_IR = 0, Retired = 0.
- rst has priority. If rst and an accept coincide, the instruction is dropped and not counted.
- Latency: an instruction accepted at edge t drives WB_Write/WB_Addr/WB_Data, or WB_Err, from edge t to edge t+1.
- WB_Write and WB_Err are high for exactly one cycle per accepted instruction.
- In cycles with no accept, WB_Write = 0 and WB_Err = 0. WB_Addr and WB_Data hold their last values.
- Back-to-back accepts give one write per cycle with no bubble.
- hold = 1 with in_valid = 1: nothing is accepted and WB_Write = 0 the next cycle. The upstream stage must keep its inputs stable until accepted.
- Inputs are sampled only at the accept edge. Changes while hold = 1 have no effect.
- Err_IR holds its value until the next misaligned load or reset.

## Test plan
- R-type add: IR = 0x00851020 (rd = 2), ALUo = 456. Next cycle: WB_Write = 1, WB_Addr = 2, WB_Data = 456. Retired = 1.
- Loads at ALUo = 0x1001, LMD = 0x12F45678:
  - lb, rt = 8: WB_Data = 0xFFFFFFF4.
  - lbu: WB_Data = 0x000000F4.
  - lh at ALUo = 0x1002 (LMD = 0x1234F678): WB_Data = 0xFFFFF678.
  - lw at ALUo = 0x1001: WB_Err = 1, WB_Write = 0, Err_IR = IR.
- Non-writing and zero-destination instructions: sw (0xAC000000), jr, beq, IR = 0, and addi with rt = 0. Each gives WB_Write = 0 the following cycle, and Retired increments by 5 in total.
- jal: IR = 0x0C000010, NPC = 0x00400008. Next cycle: WB_Addr = 31, WB_Data = 0x00400008.
- Handshake: hold = 1 for 3 cycles with in_valid = 1, giving no writes and Retired unchanged. Release hold: exactly one write one cycle later. Then 4 back-to-back accepts give 4 consecutive WB_Write pulses.
- Reset and wrap:
  - With CNT_W = 4, 17 accepts give Retired = 1.
  - Asserting rst on the same edge as an accept clears all outputs to 0, and the next cycle shows WB_Write = 0.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: decodes IR, picks ALUo / extracted LMD / NPC as
// write data, drives the register-file write port one cycle after accept,
// flags misaligned loads and counts retired instructions.
module wb_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              hold,
    output logic              in_ready,
    input  logic [DATA_W-1:0] LMD,
    input  logic [DATA_W-1:0] ALUo,
    input  logic [31:0]       IR,
    input  logic [DATA_W-1:0] NPC,
    output logic              WB_Write,
    output logic [4:0]        WB_Addr,
    output logic [DATA_W-1:0] WB_Data,
    output logic              WB_Err,
    output logic [31:0]       Err_IR,
    output logic [CNT_W-1:0]  Retired
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;

    function automatic logic [DATA_W-1:0] ext8(input logic [7:0] b, input logic sgn);
        return {{(DATA_W-8){sgn & b[7]}}, b};
    endfunction

    function automatic logic [DATA_W-1:0] ext16(input logic [15:0] h, input logic sgn);
        return {{(DATA_W-16){sgn & h[15]}}, h};
    endfunction

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       accept;
    logic       unused_ir_bits;

    assign opcode         = IR[31:26];
    assign funct          = IR[5:0];
    assign rt             = IR[20:16];
    assign rd             = IR[15:11];
    assign in_ready       = !hold;
    assign accept         = in_valid && !hold;
    assign unused_ir_bits = ^{IR[25:21], IR[10:6]};

    logic              dec_writes;
    logic [4:0]        dec_dst;
    logic [DATA_W-1:0] dec_data;
    logic              dec_mis;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;

    // Decode IR into destination, write data (with sub-word extraction) and alignment fault
    always_comb begin
        dec_writes = 1'b0;
        dec_dst    = 5'd0;
        dec_data   = ALUo;
        dec_mis    = 1'b0;
        case (ALUo[1:0])
            2'd0:    sel_byte = LMD[31:24];
            2'd1:    sel_byte = LMD[23:16];
            2'd2:    sel_byte = LMD[15:8];
            default: sel_byte = LMD[7:0];
        endcase
        sel_half = ALUo[1] ? LMD[15:0] : LMD[31:16];
        if (opcode == OP_RTYPE) begin
            if ((funct[5:3] == 3'b100) || (funct == 6'b101010) || (funct == 6'b101011) ||
                (funct == 6'b000000) || (funct == 6'b000010) || (funct == 6'b000011)) begin
                dec_writes = 1'b1;
                dec_dst    = rd;
            end
        end else if (opcode[5:3] == 3'b001) begin
            dec_writes = 1'b1;
            dec_dst    = rt;
        end else if (opcode == OP_LW) begin
            dec_writes = 1'b1;
            dec_dst    = rt;
            dec_data   = LMD;
            dec_mis    = (ALUo[1:0] != 2'b00);
        end else if ((opcode == OP_LB) || (opcode == OP_LBU)) begin
            dec_writes = 1'b1;
            dec_dst    = rt;
            dec_data   = ext8(sel_byte, opcode == OP_LB);
        end else if ((opcode == OP_LH) || (opcode == OP_LHU)) begin
            dec_writes = 1'b1;
            dec_dst    = rt;
            dec_data   = ext16(sel_half, opcode == OP_LH);
            dec_mis    = ALUo[0];
        end else if (opcode == OP_JAL) begin
            dec_writes = 1'b1;
            dec_dst    = 5'(LINK_REG);
            dec_data   = NPC;
        end
    end

    logic              wb_write_d, wb_write_q;
    logic [4:0]        wb_addr_d,  wb_addr_q;
    logic [DATA_W-1:0] wb_data_d,  wb_data_q;
    logic              wb_err_d,   wb_err_q;
    logic [31:0]       err_ir_d,   err_ir_q;
    logic [CNT_W-1:0]  retired_d,  retired_q;
    logic              do_write;
    logic              do_err;

    // Next-state: write port updates only on a real write; fault and counter on accept
    always_comb begin
        do_write   = accept && dec_writes && !dec_mis && (dec_dst != 5'd0);
        do_err     = accept && dec_mis;
        wb_write_d = do_write;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wb_err_d   = do_err;
        err_ir_d   = err_ir_q;
        retired_d  = retired_q;
        if (do_write) begin
            wb_addr_d = dec_dst;
            wb_data_d = dec_data;
        end
        if (do_err) begin
            err_ir_d = IR;
        end
        if (accept) begin
            retired_d = retired_q + 1'b1;
        end
    end

    // Output registers; reset wins over a coinciding accept
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_write_q <= 1'b0;
            wb_addr_q  <= 5'd0;
            wb_data_q  <= '0;
            wb_err_q   <= 1'b0;
            err_ir_q   <= 32'd0;
            retired_q  <= '0;
        end else begin
            wb_write_q <= wb_write_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_err_q   <= wb_err_d;
            err_ir_q   <= err_ir_d;
            retired_q  <= retired_d;
        end
    end

    assign WB_Write = wb_write_q;
    assign WB_Addr  = wb_addr_q;
    assign WB_Data  = wb_data_q;
    assign WB_Err   = wb_err_q;
    assign Err_IR   = err_ir_q;
    assign Retired  = retired_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe (CNT_W = 4 so the counter wrap is reachable).
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, hold, in_ready;
    logic [31:0] LMD, ALUo, IR, NPC;
    logic        WB_Write, WB_Err;
    logic [4:0]  WB_Addr;
    logic [31:0] WB_Data, Err_IR;
    logic [3:0]  Retired;

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_ret = 4'd0;

    wb_stage_pipe #(.DATA_W(32), .LINK_REG(31), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .hold(hold), .in_ready(in_ready),
        .LMD(LMD), .ALUo(ALUo), .IR(IR), .NPC(NPC),
        .WB_Write(WB_Write), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
        .WB_Err(WB_Err), .Err_IR(Err_IR), .Retired(Retired)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Present one instruction for exactly one edge; return 1 ns after that edge.
    task automatic issue(input logic [31:0] ir, input logic [31:0] alu,
                         input logic [31:0] lmd, input logic [31:0] npc);
        IR = ir; ALUo = alu; LMD = lmd; NPC = npc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_ret = exp_ret + 4'd1;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; hold = 1'b0;
        IR = 32'd0; ALUo = 32'd0; LMD = 32'd0; NPC = 32'd0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; exp_ret = 4'd0;
        checks++; if (WB_Write !== 1'b0) begin failures++; $display("FAIL rst_we got=%0h exp=0", WB_Write); end
        checks++; if (WB_Addr !== 5'd0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", WB_Addr); end
        checks++; if (WB_Data !== 32'd0) begin failures++; $display("FAIL rst_data got=%0h exp=0", WB_Data); end
        checks++; if (WB_Err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", WB_Err); end
        checks++; if (Err_IR !== 32'd0) begin failures++; $display("FAIL rst_errir got=%0h exp=0", Err_IR); end
        checks++; if (Retired !== 4'd0) begin failures++; $display("FAIL rst_ret got=%0h exp=0", Retired); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0h exp=1", in_ready); end
    endtask

    task automatic test_rtype();
        issue(32'h00851020, 32'd456, 32'd0, 32'd0);
        checks++; if (WB_Write !== 1'b1) begin failures++; $display("FAIL add_we got=%0h exp=1", WB_Write); end
        checks++; if (WB_Addr !== 5'd2) begin failures++; $display("FAIL add_addr got=%0h exp=2", WB_Addr); end
        checks++; if (WB_Data !== 32'd456) begin failures++; $display("FAIL add_data got=%0h exp=1c8", WB_Data); end
        checks++; if (Retired !== 4'd1) begin failures++; $display("FAIL add_ret got=%0h exp=1", Retired); end
        idle_cycle();
        checks++; if (WB_Write !== 1'b0) begin failures++; $display("FAIL add_we_drop got=%0h exp=0", WB_Write); end
        checks++; if (WB_Data !== 32'd456) begin failures++; $display("FAIL add_data_hold got=%0h exp=1c8", WB_Data); end
        // sll $3,$2,2 writes rd = 3
        issue(32'h00021880, 32'h0000_0077, 32'd0, 32'd0);
        checks++; if (WB_Write !== 1'b1 || WB_Addr !== 5'd3 || WB_Data !== 32'h77) begin
            failures++; $display("FAIL sll_wr got=%0h/%0h/%0h exp=1/3/77", WB_Write, WB_Addr, WB_Data); end
        // R-type funct 000001 is not a writing instruction
        issue(32'h00021881, 32'h0000_0055, 32'd0, 32'd0);
        checks++; if (WB_Write !== 1'b0 || WB_Data !== 32'h77) begin
            failures++; $display("FAIL badfunct got=%0h/%0h exp=0/77", WB_Write, WB_Data); end
    endtask

    task automatic test_loads();
        issue(32'h80080000, 32'h1001, 32'h12F45678, 32'd0);   // lb k=1
        checks++; if (WB_Write !== 1'b1 || WB_Addr !== 5'd8 || WB_Data !== 32'hFFFFFFF4) begin
            failures++; $display("FAIL lb1 got=%0h/%0h/%0h exp=1/8/fffffff4", WB_Write, WB_Addr, WB_Data); end
        issue(32'h90080000, 32'h1001, 32'h12F45678, 32'd0);   // lbu k=1
        checks++; if (WB_Data !== 32'h000000F4) begin failures++; $display("FAIL lbu1 got=%0h exp=f4", WB_Data); end
        issue(32'h80080000, 32'h1000, 32'h92F45678, 32'd0);   // lb k=0
        checks++; if (WB_Data !== 32'hFFFFFF92) begin failures++; $display("FAIL lb0 got=%0h exp=ffffff92", WB_Data); end
        issue(32'h80080000, 32'h1003, 32'h12F45678, 32'd0);   // lb k=3
        checks++; if (WB_Data !== 32'h00000078) begin failures++; $display("FAIL lb3 got=%0h exp=78", WB_Data); end
        issue(32'h84080000, 32'h1002, 32'h1234F678, 32'd0);   // lh upper-address half
        checks++; if (WB_Data !== 32'hFFFFF678) begin failures++; $display("FAIL lh2 got=%0h exp=fffff678", WB_Data); end
        issue(32'h94080000, 32'h1000, 32'h8234F678, 32'd0);   // lhu first half
        checks++; if (WB_Data !== 32'h00008234) begin failures++; $display("FAIL lhu0 got=%0h exp=8234", WB_Data); end
        issue(32'h8C080000, 32'h1000, 32'hCAFEBABE, 32'd0);   // aligned lw
        checks++; if (WB_Write !== 1'b1 || WB_Data !== 32'hCAFEBABE) begin
            failures++; $display("FAIL lw got=%0h/%0h exp=1/cafebabe", WB_Write, WB_Data); end
        issue(32'h8C080000, 32'h1001, 32'h12F45678, 32'd0);   // misaligned lw
        checks++; if (WB_Err !== 1'b1) begin failures++; $display("FAIL lwmis_err got=%0h exp=1", WB_Err); end
        checks++; if (WB_Write !== 1'b0) begin failures++; $display("FAIL lwmis_we got=%0h exp=0", WB_Write); end
        checks++; if (Err_IR !== 32'h8C080000) begin failures++; $display("FAIL lwmis_errir got=%0h exp=8c080000", Err_IR); end
        checks++; if (WB_Data !== 32'hCAFEBABE) begin failures++; $display("FAIL lwmis_data got=%0h exp=cafebabe", WB_Data); end
        issue(32'h00851020, 32'd9, 32'd0, 32'd0);             // add after fault
        checks++; if (WB_Err !== 1'b0 || WB_Write !== 1'b1) begin
            failures++; $display("FAIL err_pulse got=%0h/%0h exp=0/1", WB_Err, WB_Write); end
        checks++; if (Err_IR !== 32'h8C080000) begin failures++; $display("FAIL errir_hold got=%0h exp=8c080000", Err_IR); end
        issue(32'h84090000, 32'h1003, 32'h12345678, 32'd0);   // misaligned lh
        checks++; if (WB_Err !== 1'b1 || WB_Write !== 1'b0 || Err_IR !== 32'h84090000) begin
            failures++; $display("FAIL lhmis got=%0h/%0h/%0h exp=1/0/84090000", WB_Err, WB_Write, Err_IR); end
        checks++; if (Retired !== exp_ret) begin failures++; $display("FAIL loads_ret got=%0h exp=%0h", Retired, exp_ret); end
    endtask

    task automatic test_nowrite();
        logic [31:0] irs [5];
        logic [3:0]  start;
        irs[0] = 32'hAC000000;  // sw
        irs[1] = 32'h03E00008;  // jr $31
        irs[2] = 32'h10000004;  // beq
        irs[3] = 32'h00000000;  // sll $0,$0,0
        irs[4] = 32'h20000005;  // addi rt=0
        start = exp_ret;
        for (int i = 0; i < 5; i++) begin
            issue(irs[i], 32'h0000_1234, 32'h0000_5678, 32'h0000_0004);
            checks++; if (WB_Write !== 1'b0 || WB_Err !== 1'b0) begin
                failures++; $display("FAIL nowrite%0d got=%0h/%0h exp=0/0", i, WB_Write, WB_Err); end
        end
        checks++; if (Retired !== start + 4'd5) begin
            failures++; $display("FAIL nowrite_ret got=%0h exp=%0h", Retired, start + 4'd5); end
    endtask

    task automatic test_jal();
        issue(32'h0C000010, 32'h0, 32'h0, 32'h00400008);
        checks++; if (WB_Write !== 1'b1 || WB_Addr !== 5'd31 || WB_Data !== 32'h00400008) begin
            failures++; $display("FAIL jal got=%0h/%0h/%0h exp=1/1f/400008", WB_Write, WB_Addr, WB_Data); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] start;
        start = exp_ret;
        IR = 32'h2009000A; ALUo = 32'h11; hold = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin IR = 32'h200A000A; ALUo = 32'h22; end
            checks++; if (WB_Write !== 1'b0 || in_ready !== 1'b0 || Retired !== start) begin
                failures++; $display("FAIL hold%0d got=%0h/%0h/%0h exp=0/0/%0h", i, WB_Write, in_ready, Retired, start); end
        end
        hold = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_ret = exp_ret + 4'd1;
        checks++; if (WB_Write !== 1'b1 || WB_Addr !== 5'd10 || WB_Data !== 32'h22) begin
            failures++; $display("FAIL release got=%0h/%0h/%0h exp=1/a/22", WB_Write, WB_Addr, WB_Data); end
        idle_cycle();
        checks++; if (WB_Write !== 1'b0) begin failures++; $display("FAIL release_once got=%0h exp=0", WB_Write); end
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            IR = 32'h20000000 | (32'(i + 1) << 16);
            ALUo = 32'(100 + i);
            @(posedge clk); #1;
            checks++; if (WB_Write !== 1'b1 || WB_Addr !== 5'(i + 1) || WB_Data !== 32'(100 + i)) begin
                failures++; $display("FAIL b2b%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, WB_Write, WB_Addr, WB_Data, i + 1, 100 + i); end
        end
        in_valid = 1'b0;
        exp_ret = exp_ret + 4'd4;
        checks++; if (Retired !== exp_ret) begin failures++; $display("FAIL b2b_ret got=%0h exp=%0h", Retired, exp_ret); end
    endtask

    task automatic test_wrap();
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0; exp_ret = 4'd0;
        for (int i = 0; i < 17; i++) issue(32'h00000000, 32'h0, 32'h0, 32'h0);
        checks++; if (Retired !== 4'd1) begin failures++; $display("FAIL wrap got=%0h exp=1", Retired); end
    endtask

    task automatic test_reset_accept();
        issue(32'h8C080000, 32'h1002, 32'h0, 32'h0);          // leave Err_IR nonzero
        issue(32'h00851020, 32'h5A5A, 32'h0, 32'h0);          // leave write port nonzero
        IR = 32'h00851020; ALUo = 32'h1234; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (WB_Write !== 1'b0 || WB_Addr !== 5'd0 || WB_Data !== 32'd0) begin
            failures++; $display("FAIL rstacc_wr got=%0h/%0h/%0h exp=0/0/0", WB_Write, WB_Addr, WB_Data); end
        checks++; if (WB_Err !== 1'b0 || Err_IR !== 32'd0 || Retired !== 4'd0) begin
            failures++; $display("FAIL rstacc_misc got=%0h/%0h/%0h exp=0/0/0", WB_Err, Err_IR, Retired); end
        idle_cycle();
        checks++; if (WB_Write !== 1'b0 || Retired !== 4'd0) begin
            failures++; $display("FAIL rstacc_next got=%0h/%0h exp=0/0", WB_Write, Retired); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_loads();
        test_nowrite();
        test_jal();
        test_back_to_back();
        test_wrap();
        test_reset_accept();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
